ip_sram_ctrl: RTL

IP_SRAM_CTRL -- requirements
Module: ip_sram_ctrl

---
 rtl/ip_sram_ctrl_pkg.sv | 45 ++++
 rtl/ip_sram_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ip_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ip_sram_ctrl_pkg
//  Description : Shared types and constants for the megarom SRAM controller:
//                FSM state encoding, access-length limits, request record and
//                a helper that folds the access length into its legal range.
//  Revision    : 1.0 - initial release
// ============================================================================
package ip_sram_ctrl_pkg;

    localparam int c_ADDR_W   = 22;
    localparam int c_DATA_W   = 8;
    localparam int c_CNT_W    = 4;

    // Legal range of strobe-active access cycles.
    localparam int c_WAIT_MIN = 1;
    localparam int c_WAIT_MAX = 15;

    // Controller FSM encoding.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    // One captured mapper request.
    typedef struct packed {
        logic                is_write;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } sram_req_t;

    // Out-of-range access lengths are pulled back to the nearest legal value
    // so the down-counter can never wrap or underflow.
    function automatic int clamp_wait(input int w);
        if (w < c_WAIT_MIN) begin
            return c_WAIT_MIN;
        end
        if (w > c_WAIT_MAX) begin
            return c_WAIT_MAX;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ip_sram_ctrl
//  Description : Asynchronous SRAM controller for the megarom mapper. Turns
//                rising edges of the rd/wr request levels into SETUP / ACCESS /
//                HOLD bus cycles, with a one-entry pending slot for requests
//                that arrive while a cycle is in progress.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset          : clock, asynchronous active-high reset
//    rd, wr              : request levels (both rising together = write)
//    address, wdata      : request byte address and write data
//    busy                : controller occupied (FSM active or slot full)
//    rdata, rdata_en     : read data (held) and one-cycle completion strobe
//    overrun             : sticky, a request was dropped
//    sram_addr, sram_dq_o, sram_dq_oe, sram_dq_i : external SRAM bus
//    sram_ce_n, sram_oe_n, sram_we_n             : active-low SRAM strobes
// ============================================================================
module ip_sram_ctrl
    import ip_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd,
    input  logic                wr,
    input  logic [c_ADDR_W-1:0] address,
    input  logic [c_DATA_W-1:0] wdata,
    output logic                busy,
    output logic [c_DATA_W-1:0] rdata,
    output logic                rdata_en,
    output logic                overrun,
    output logic [c_ADDR_W-1:0] sram_addr,
    output logic [c_DATA_W-1:0] sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [c_DATA_W-1:0] sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);

    localparam int               c_WAIT_EFF  = clamp_wait(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(c_WAIT_EFF - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    sram_req_t           r_cur;
    sram_req_t           r_pend;
    logic                r_pend_vld;
    logic                r_req_prev;
    logic [c_DATA_W-1:0] r_rdata;
    logic                r_rdata_en;
    logic                r_overrun;
    logic                r_busy;
    logic                r_ce_n;
    logic                r_oe_n;
    logic                r_we_n;
    logic                r_dq_oe;

    // ------------------------------------------------------------------------
    // Request edge detection and capture
    // ------------------------------------------------------------------------
    logic      w_req_lvl;
    logic      w_det;
    sram_req_t w_new;

    assign w_req_lvl = rd | wr;
    assign w_det     = w_req_lvl & ~r_req_prev;
    // A simultaneous rd+wr rise becomes a write: the type is simply wr.
    assign w_new     = '{is_write: wr, addr: address, wdata: wdata};

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    sram_req_t          w_cur_nxt;
    sram_req_t          w_pend_nxt;
    logic               w_pend_vld_nxt;
    logic               w_ovr_nxt;
    logic               w_sample;
    logic               w_in_cycle;

    assign w_in_cycle = (r_state == c_ST_SETUP) || (r_state == c_ST_ACCESS);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_nxt      = r_cur;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_ovr_nxt      = r_overrun;
        w_sample       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_det) begin
                    w_cur_nxt   = w_new;
                    w_state_nxt = c_ST_SETUP;
                end
            end
            c_ST_SETUP: begin
                w_state_nxt = c_ST_ACCESS;
                w_cnt_nxt   = c_WAIT_LOAD;
            end
            c_ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_ST_HOLD;
                    w_sample    = ~r_cur.is_write;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (r_pend_vld) begin
                    // Consume the slot; a request arriving on this same edge
                    // refills it instead of being dropped.
                    w_cur_nxt   = r_pend;
                    w_state_nxt = c_ST_SETUP;
                    if (w_det) begin
                        w_pend_nxt = w_new;
                    end else begin
                        w_pend_vld_nxt = 1'b0;
                    end
                end else if (w_det) begin
                    // Empty slot: chain the new request straight into SETUP
                    // rather than parking it in the slot while going IDLE.
                    w_cur_nxt   = w_new;
                    w_state_nxt = c_ST_SETUP;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        if (w_det && w_in_cycle) begin
            if (!r_pend_vld) begin
                w_pend_nxt     = w_new;
                w_pend_vld_nxt = 1'b1;
            end else begin
                w_ovr_nxt = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers. Bus strobes, busy and rdata_en are registered from the next
    // state so the SRAM pins are glitch-free and drop inactive on reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_cur      <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            // The edge register resets to "level already seen", so a request
            // held high across reset release is ignored until it re-rises.
            r_req_prev <= 1'b1;
            r_rdata    <= '0;
            r_rdata_en <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_dq_oe    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur      <= w_cur_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_req_prev <= w_req_lvl;
            r_overrun  <= w_ovr_nxt;
            if (w_sample) begin
                r_rdata <= sram_dq_i;
            end
            r_rdata_en <= (w_state_nxt == c_ST_HOLD) && !w_cur_nxt.is_write;
            r_busy     <= (w_state_nxt != c_ST_IDLE) || w_pend_vld_nxt;
            r_ce_n     <= (w_state_nxt == c_ST_IDLE);
            r_oe_n     <= !((w_state_nxt == c_ST_ACCESS) && !w_cur_nxt.is_write);
            r_we_n     <= !((w_state_nxt == c_ST_ACCESS) && w_cur_nxt.is_write);
            // Only writes drive the bus, so it is never driven while oe_n is low.
            r_dq_oe    <= (w_state_nxt != c_ST_IDLE) && w_cur_nxt.is_write;
        end
    end

    assign busy       = r_busy;
    assign rdata      = r_rdata;
    assign rdata_en   = r_rdata_en;
    assign overrun    = r_overrun;
    assign sram_addr  = r_cur.addr;
    assign sram_dq_o  = r_cur.wdata;
    assign sram_dq_oe = r_dq_oe;
    assign sram_ce_n  = r_ce_n;
    assign sram_oe_n  = r_oe_n;
    assign sram_we_n  = r_we_n;

endmodule
`default_nettype wire
